// File: rtl/sb_rx_txn_ctrl.sv
// Sideband receive transaction controller: symbol deserializer, DLE-framed byte FSM
// and CRC-16 checker sequencing.
module sb_rx_txn_ctrl #(
    parameter int DATA_W    = 8,
    parameter int MAX_BYTES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_bit,
    input  logic              bit_valid,
    output logic              crc_init,
    output logic              crc_shift,
    output logic              crc_data,
    input  logic              crc_zero,
    output logic [DATA_W-1:0] byte_out,
    output logic              byte_valid,
    output logic              txn_start,
    output logic              txn_done,
    output logic              txn_crc_ok,
    output logic              txn_err,
    output logic [1:0]        err_code
);

    localparam logic [DATA_W-1:0] DLE = DATA_W'(8'hFE);
    localparam logic [DATA_W-1:0] STX = DATA_W'(8'h05);
    localparam logic [DATA_W-1:0] ETX = DATA_W'(8'h40);
    localparam logic [3:0]        STOP_CNT = 4'(DATA_W + 1);
    localparam logic [6:0]        LEN_MAX  = 7'(MAX_BYTES);

    typedef enum logic [1:0] {HUNT, GOT_DLE, PAYLOAD, PAY_DLE} state_t;

    state_t            state, state_nxt;
    logic [3:0]        sym_cnt;
    logic [DATA_W-1:0] sym_sr;
    logic [6:0]        len;
    logic              feed_act;
    logic [2:0]        feed_cnt;
    logic [DATA_W-1:0] feed_sr;

    logic              evt_vld_p0;
    logic [DATA_W-1:0] evt_byte_p0;
    logic              evt_ok_p0;
    logic              start_nxt, commit_nxt, done_nxt, err_nxt;
    logic [1:0]        code_nxt;

    // Stage p0: line bits into symbols; byte event on the stop-bit strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sym_cnt <= 4'd0;
        end else if (bit_valid) begin
            if (sym_cnt == 4'd0) begin
                if (!rx_bit) sym_cnt <= 4'd1;
            end else if (sym_cnt == STOP_CNT) begin
                sym_cnt <= 4'd0;
            end else begin
                sym_cnt <= sym_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bit_valid && sym_cnt != 4'd0 && sym_cnt != STOP_CNT)
            sym_sr <= {rx_bit, sym_sr[DATA_W-1:1]};
    end

    assign evt_vld_p0  = bit_valid && (sym_cnt == STOP_CNT);
    assign evt_byte_p0 = sym_sr;
    assign evt_ok_p0   = rx_bit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= HUNT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (evt_vld_p0) begin
            case (state)
                HUNT:    if (evt_ok_p0 && evt_byte_p0 == DLE) state_nxt = GOT_DLE;
                GOT_DLE: begin
                    if (!evt_ok_p0)                state_nxt = HUNT;
                    else if (evt_byte_p0 == STX)   state_nxt = PAYLOAD;
                    else if (evt_byte_p0 != DLE)   state_nxt = HUNT;
                end
                PAYLOAD: begin
                    if (err_nxt)                   state_nxt = HUNT;
                    else if (evt_byte_p0 == DLE)   state_nxt = PAY_DLE;
                end
                PAY_DLE: state_nxt = (err_nxt || done_nxt) ? HUNT : PAYLOAD;
                default: state_nxt = HUNT;
            endcase
        end
    end

    // A commit at len == MAX_BYTES would overflow, so it aborts instead of outputting
    always_comb begin
        start_nxt  = 1'b0;
        commit_nxt = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        code_nxt   = 2'd0;
        if (evt_vld_p0) begin
            case (state)
                GOT_DLE: start_nxt = evt_ok_p0 && (evt_byte_p0 == STX);
                PAYLOAD: begin
                    if (!evt_ok_p0) begin
                        err_nxt = 1'b1; code_nxt = 2'd1;
                    end else if (evt_byte_p0 != DLE) begin
                        if (len == LEN_MAX) begin err_nxt = 1'b1; code_nxt = 2'd3; end
                        else                commit_nxt = 1'b1;
                    end
                end
                PAY_DLE: begin
                    if (!evt_ok_p0) begin
                        err_nxt = 1'b1; code_nxt = 2'd1;
                    end else if (evt_byte_p0 == DLE) begin
                        if (len == LEN_MAX) begin err_nxt = 1'b1; code_nxt = 2'd3; end
                        else                commit_nxt = 1'b1;
                    end else if (evt_byte_p0 == ETX) begin
                        if (len < 7'd3) begin err_nxt = 1'b1; code_nxt = 2'd0; end
                        else            done_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1; code_nxt = 2'd2;
                    end
                end
                default: ;
            endcase
        end
    end

    // Stage p1: registered one-cycle pulses and transaction bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_valid <= 1'b0;
            byte_out   <= '0;
            txn_start  <= 1'b0;
            crc_init   <= 1'b0;
            txn_done   <= 1'b0;
            txn_crc_ok <= 1'b0;
            txn_err    <= 1'b0;
            err_code   <= 2'd0;
            len        <= 7'd0;
        end else begin
            byte_valid <= commit_nxt;
            txn_start  <= start_nxt;
            crc_init   <= start_nxt;
            txn_done   <= done_nxt;
            txn_crc_ok <= done_nxt & crc_zero;
            txn_err    <= err_nxt;
            if (commit_nxt) byte_out <= evt_byte_p0;
            if (err_nxt)    err_code <= code_nxt;
            if (start_nxt)       len <= 7'd0;
            else if (commit_nxt) len <= len + 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            feed_act <= 1'b0;
            feed_cnt <= 3'd0;
        end else if (err_nxt) begin
            feed_act <= 1'b0;
            feed_cnt <= 3'd0;
        end else if (commit_nxt) begin
            feed_act <= 1'b1;
            feed_cnt <= 3'd0;
        end else if (feed_act) begin
            feed_cnt <= feed_cnt + 3'd1;
            if (feed_cnt == 3'd7) feed_act <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit_nxt)    feed_sr <= evt_byte_p0;
        else if (feed_act) feed_sr <= feed_sr >> 1;
    end

    assign crc_shift = feed_act;
    assign crc_data  = feed_act & feed_sr[0];

endmodule

// File: tb/tb_sb_rx_txn_ctrl.sv
// Directed bench for sb_rx_txn_ctrl: framed byte streams with a stubbed CRC residue.
module tb_sb_rx_txn_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_bit = 1'b1;
    logic       bit_valid = 1'b0;
    logic       crc_zero = 1'b0;
    logic       crc_init, crc_shift, crc_data;
    logic [7:0] byte_out;
    logic       byte_valid, txn_start, txn_done, txn_crc_ok, txn_err;
    logic [1:0] err_code;

    int n_chk = 0;
    int n_fail = 0;

    int n_bv = 0, n_sh = 0, n_start = 0, n_init = 0, n_done = 0, n_err = 0;
    logic       last_ok = 1'b0;
    logic [1:0] last_code = 2'd0;
    logic [7:0] bytes_q[$];
    logic       shbits_q[$];

    always #5 clk = ~clk;

    sb_rx_txn_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .rx_bit     (rx_bit),
        .bit_valid  (bit_valid),
        .crc_init   (crc_init),
        .crc_shift  (crc_shift),
        .crc_data   (crc_data),
        .crc_zero   (crc_zero),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .txn_start  (txn_start),
        .txn_done   (txn_done),
        .txn_crc_ok (txn_crc_ok),
        .txn_err    (txn_err),
        .err_code   (err_code)
    );

    always @(negedge clk) begin
        if (byte_valid) begin bytes_q.push_back(byte_out); n_bv++; end
        if (crc_shift)  begin shbits_q.push_back(crc_data); n_sh++; end
        if (txn_start)  n_start++;
        if (crc_init)   n_init++;
        if (txn_done)   begin n_done++; last_ok = txn_crc_ok; end
        if (txn_err)    begin n_err++; last_code = err_code; end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        rx_bit = b;
        bit_valid = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
    endtask

    // Returns at the negedge inside cycle T+1 of the stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_bit = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [7:0] sh_byte(input int base);
        logic [7:0] v;
        for (int k = 0; k < 8; k++) v[k] = shbits_q[base + k];
        return v;
    endfunction

    initial begin
        int b_bv, b_sh, b_start, b_init, b_done, b_err, qb, sb;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", {crc_init, crc_shift, crc_data, byte_out, byte_valid,
                              txn_start, txn_done, txn_crc_ok, txn_err, err_code}, 32'h0);
        chk("reset_state", {dut.state, dut.sym_cnt, dut.len, dut.feed_cnt}, 32'h0);
        reset = 1'b1;
        idle(4);
        chk("post_reset_outputs", {crc_init, crc_shift, byte_valid, txn_start,
                                   txn_done, txn_err}, 32'h0);

        // Good frame
        crc_zero = 1'b1;
        b_bv = n_bv; b_sh = n_sh; b_start = n_start; b_init = n_init;
        b_done = n_done; b_err = n_err; qb = bytes_q.size(); sb = shbits_q.size();
        send_byte(8'hFE); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
        send_byte(8'hFE); send_byte(8'h40);
        chk("good_done_pulse", {txn_done, txn_crc_ok}, 32'h3);
        idle(12);
        chk("good_start", n_start - b_start, 1);
        chk("good_init", n_init - b_init, 1);
        chk("good_bv", n_bv - b_bv, 4);
        chk("good_bytes", {bytes_q[qb], bytes_q[qb+1], bytes_q[qb+2], bytes_q[qb+3]},
            32'h11223344);
        chk("good_shift", n_sh - b_sh, 32);
        chk("good_crc_data_11", sh_byte(sb), 8'h11);
        chk("good_crc_data_44", sh_byte(sb + 24), 8'h44);
        chk("good_done", n_done - b_done, 1);
        chk("good_crc_ok", last_ok, 1);
        chk("good_no_err", n_err - b_err, 0);

        // DLE stuffing
        crc_zero = 1'b0;
        b_bv = n_bv; b_done = n_done; qb = bytes_q.size();
        send_byte(8'hFE); send_byte(8'h05);
        send_byte(8'hFE); send_byte(8'hFE); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'hFE); send_byte(8'h40);
        idle(12);
        chk("stuff_bv", n_bv - b_bv, 3);
        chk("stuff_bytes", {8'h00, bytes_q[qb], bytes_q[qb+1], bytes_q[qb+2]}, 32'h00FE2233);
        chk("stuff_len", dut.len, 3);
        chk("stuff_done", n_done - b_done, 1);
        chk("stuff_crc_ok", last_ok, 0);

        // Bad escape, then restart
        b_start = n_start; b_done = n_done;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11);
        send_byte(8'hFE); send_byte(8'h07);
        chk("badesc_err", {txn_err, err_code}, {29'h0, 1'b1, 2'd2});
        idle(12);
        chk("badesc_hunt", dut.state, 0);
        crc_zero = 1'b1;
        send_byte(8'hFE); send_byte(8'h05);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
        send_byte(8'hFE); send_byte(8'h40);
        idle(12);
        chk("restart_start", n_start - b_start, 2);
        chk("restart_done", n_done - b_done, 1);

        // Framing error on third payload byte
        b_bv = n_bv;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33, 1'b0);
        chk("framing_err", {txn_err, err_code}, {29'h0, 1'b1, 2'd1});
        idle(12);
        chk("framing_bv", n_bv - b_bv, 2);

        // Short frame
        b_err = n_err; b_done = n_done;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11);
        send_byte(8'hFE); send_byte(8'h40);
        idle(12);
        chk("short_err", n_err - b_err, 1);
        chk("short_code", last_code, 0);
        chk("short_no_done", n_done - b_done, 0);

        // Overflow
        b_bv = n_bv; b_sh = n_sh; b_err = n_err; qb = bytes_q.size();
        send_byte(8'hFE); send_byte(8'h05);
        for (int i = 0; i < 65; i++) send_byte(8'(8'h10 + i));
        chk("ovf_err", {txn_err, err_code, byte_valid, crc_shift},
            {27'h0, 1'b1, 2'd3, 1'b0, 1'b0});
        idle(12);
        chk("ovf_bv", n_bv - b_bv, 64);
        chk("ovf_last_byte", bytes_q[qb + 63], 8'h4F);
        chk("ovf_shift", n_sh - b_sh, 512);
        chk("ovf_err_count", n_err - b_err, 1);

        // Reset during the 4th crc_shift cycle
        b_err = n_err;
        send_byte(8'hFE); send_byte(8'h05); send_byte(8'h11);
        repeat (3) @(negedge clk);
        chk("mid_shift_active", crc_shift, 1);
        reset = 1'b0;
        #1;
        chk("mid_reset_outputs", {crc_init, crc_shift, crc_data, byte_out, byte_valid,
                                  txn_start, txn_done, txn_crc_ok, txn_err, err_code}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        b_bv = n_bv; b_sh = n_sh; b_start = n_start; b_done = n_done;
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        idle(4);
        chk("idle_nothing", {n_bv - b_bv, n_sh - b_sh, n_start - b_start}, 0);
        send_byte(8'hFE); send_byte(8'h05);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'hFE); send_byte(8'h40);
        idle(12);
        chk("fresh_done", n_done - b_done, 1);
        chk("reset_no_err", n_err - b_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sb_rx_txn_ctrl.md
# sb_rx_txn_ctrl

Receive-side sideband transaction controller for the USB4 logical layer. It deserializes the bit-serial sideband stream, which uses 10-bit symbols (start 0, 8 data bits LSB-first, stop 1), and frames transactions as DLE STX … DLE ETX with DLE stuffing. It sequences the bit-serial CRC-16 checker by initialising it, shifting each unstuffed payload byte into it, and sampling its residue at end of frame to report the transaction status.

## Interface
- DLE, 8'hFE: escape byte
- STX, 8'h05: start-of-transaction byte following DLE
- ETX, 8'h40: end-of-transaction byte following DLE
- MAX_BYTES, 64: maximum unstuffed payload bytes per transaction, including the 2 CRC bytes
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- rx_bit  in  1  sideband line bit, sampled only when bit_valid=1
- bit_valid  in  1  one-cycle strobe per line bit; consecutive strobes are ≥1 clock apart
- crc_init  out  1  one-cycle pulse; CRC engine loads 16'hFFFF
- crc_shift  out  1  CRC engine shifts one bit this cycle
- crc_data  out  1  bit shifted into the CRC engine
- crc_zero  in  1  CRC engine residue == 16'h0000
- byte_out  out  8  unstuffed payload byte (CRC bytes included)
- byte_valid  out  1  one-cycle qualifier for byte_out
- txn_start  out  1  pulse when DLE STX is accepted
- txn_done  out  1  pulse at a valid DLE ETX
- txn_crc_ok  out  1  valid with txn_done; copy of crc_zero
- txn_err  out  1  pulse on an aborted transaction
- err_code  out  2  valid with txn_err: 0 short, 1 framing, 2 bad escape, 3 overflow

## Operation
- **Symbol deserializer.** A 4-bit counter, sym_cnt, covers 0..9.
  - When sym_cnt=0, a sampled 0 is a start bit and sets sym_cnt=1. A sampled 1 is idle and is ignored.
  - sym_cnt 1..8 shift data bits in LSB-first.
  - sym_cnt=9 checks the stop bit, produces a byte event, and returns sym_cnt to 0.
  - If the stop bit is 0, the event is a framing event.
- **Byte FSM states:** HUNT, GOT_DLE, PAYLOAD, PAY_DLE.
  - HUNT: a DLE goes to GOT_DLE. Any other byte stays in HUNT. A framing event stays in HUNT with no error.
  - GOT_DLE: STX pulses txn_start and crc_init, clears len, and goes to PAYLOAD. DLE stays in GOT_DLE. Any other byte goes to HUNT with no error.
  - PAYLOAD: a non-DLE byte commits that byte. DLE goes to PAY_DLE.
  - PAY_DLE: DLE commits 8'hFE and goes to PAYLOAD. ETX ends the frame and goes to HUNT. Any other byte is a bad-escape abort (code 2).
  - ETX with len<3 is a short abort (code 0) instead of txn_done.
  - A framing event in PAYLOAD or PAY_DLE is a framing abort (code 1).
- **Commit.** Each commit pulses byte_valid with byte_out, increments len (7-bit), and starts a CRC feed.
- **Overflow.** A commit that would make len exceed MAX_BYTES is an overflow abort (code 3). That byte is not output.
- **CRC feed.**
  - crc_shift=1 for exactly 8 consecutive clocks.
  - crc_data = committed byte bit k on feed cycle k, k=0..7.
  - A 3-bit feed counter and a feed shift register hold the byte.
- **Frame end.** At ETX: txn_done=1 and txn_crc_ok=crc_zero.
- **Abort.** txn_err pulses with err_code, and the FSM goes to HUNT. Any CRC feed in progress is cancelled.
- **Reset values.** Every output is 0 and err_code=2'd0. The FSM is in HUNT, and sym_cnt, len and the feed counter are 0.
- **Reset mid-transaction.** The transaction is discarded silently; no txn_err is produced.

## Timing
- A byte event occurs on the clock edge that samples the stop bit (cycle T).
- FSM outputs (byte_valid, txn_start, crc_init, txn_done, txn_err) are registered and asserted during T+1, for one cycle only.
- CRC feed:
  - crc_shift spans T+1 .. T+8.
  - A byte spans ≥10 bit strobes, so a feed always completes before the next byte event.
  - A simultaneous new commit is therefore impossible and needs no arbitration.
- crc_zero is sampled at edge T of the ETX stop bit. The last feed ended ≥2 clocks earlier, so the residue is settled.
- crc_init at T+1 precedes the first feed, which starts at the earliest at T+11.
- A bit_valid in the same cycle as any output pulse is processed normally; the deserializer never stalls.

## Test plan
- **Good frame.** Stream FE 05 11 22 33 44 FE 40 with the CRC stub returning crc_zero=1 at ETX.
  - txn_start, crc_init once.
  - byte_valid ×4 with 11, 22, 33, 44.
  - 32 crc_shift cycles; crc_data for 8'h11 is 1,0,0,0,1,0,0,0.
  - txn_done=1 and txn_crc_ok=1.
- **DLE stuffing.** FE 05 FE FE 22 33 FE 40.
  - Bytes FE, 22, 33 output (3 commits), len=3.
  - txn_done; with crc_zero=0, txn_crc_ok=0.
- **Bad escape.** FE 05 11 FE 07.
  - txn_err=1, err_code=2 in the cycle after the 07 stop bit.
  - FSM in HUNT; a following FE 05 restarts normally.
- **Framing and short.** Stop bit 0 on the third payload byte gives err_code=1. Separately, FE 05 11 FE 40 gives err_code=0 and no txn_done.
- **Overflow.** 65 non-DLE payload bytes with MAX_BYTES=64.
  - 64 byte_valid pulses, then txn_err with err_code=3.
  - The 65th byte is not output and produces no crc_shift.
- **Reset mid-operation.** Assert reset during the 4th crc_shift cycle.
  - All outputs 0 immediately.
  - After release, idle 1s produce nothing, and a fresh good frame completes with txn_done.
